trans_dispatcher: RTL and testbench
===================================

# trans_dispatcher

Input scheduler in front of the transaction validator. It buffers incoming 128-bit transaction words in a small FIFO and presents them to the validator with backpressure to upstream. It releases exactly one transaction at a time, only while the validator is idle, and watches the validator for hangs. The validator has no ready signal, so this block is the only legal source of its `valid_i`.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: transaction buffer depth; power of two, ≥2.
- `ACK_WINDOW`, 2: cycles after issue within which `val_busy_i` must rise.
- `BUSY_TIMEOUT`, 32768: max cycles `val_busy_i` may stay high per transaction.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_data_i` in 128: transaction word {sender 48, receiver 48, amount 22, flags 10}; bit 9 = block start.
- `in_valid_i` in 1: upstream word valid.
- `in_ready_o` out 1: FIFO not full; accept on `in_valid_i && in_ready_o`.
- `val_data_o` out 128: word to validator `data_i`.
- `val_valid_o` out 1: one-cycle issue pulse to validator `valid_i`.
- `val_busy_i` in 1: validator not in its wait-for-transaction state.
- `issue_err_o` out 1: one-cycle pulse, busy not seen within `ACK_WINDOW`.
- `timeout_o` out 1: one-cycle pulse, busy exceeded `BUSY_TIMEOUT`.
- `dispatched_cnt_o` out 32: transactions issued since reset, wraps.
- `block_cnt_o` out 16: issued words with bit 9 set, wraps.

## Operation
- FIFO push on accept. Pop only on issue. `in_ready_o = !full`, derived from the registered count. A pop in the same cycle does not raise ready.
- FSM states:
  - IDLE: if FIFO non-empty and `val_busy_i==0`, register `val_data_o <= head`, `val_valid_o <= 1`, pop, increment `dispatched_cnt_o` (and `block_cnt_o` if head bit 9), go to ACK. Otherwise stay.
  - ACK: if `val_busy_i`, clear timer and go to RUN. Otherwise increment the window counter. When it reaches `ACK_WINDOW`, pulse `issue_err_o` and go to IDLE. The word is dropped, not retried.
  - RUN: if `!val_busy_i`, go to IDLE. Otherwise increment the timer. When the timer reaches `BUSY_TIMEOUT`, pulse `timeout_o` and go to IDLE. Busy-low gating in IDLE then blocks issue until the validator recovers.
- `val_valid_o` is high only in the cycle after the IDLE issue decision, never two cycles in a row.
- `val_data_o` holds its last value between issues.
- Counters wrap modulo 2^width without saturation.
- Simultaneous push into an empty FIFO and issue check: the new word is not issued in that cycle. It is eligible next cycle.
- Push and pop in the same cycle when full is impossible (ready low). Push and pop when partially full: count is unchanged.
- Reset, asynchronous, at any time: FSM to IDLE, FIFO empty.
  - Outputs: `in_ready_o=1` (after reset deassert), `val_valid_o=0`, `val_data_o=0`, `issue_err_o=0`, `timeout_o=0`, counters 0.
  - Reset mid-RUN discards the in-flight word. The validator is reset by its own means.

## Timing
- Minimum latency from accept edge N to `val_valid_o` high: cycle N+2 (FIFO write at N, IDLE decision at N+1, registered pulse at N+2).
- The validator raises busy one cycle after `val_valid_o`, so ACK normally exits on its first cycle.
- Back-to-back throughput: one transaction per (validator busy duration + 2) cycles.
- `issue_err_o` asserts `ACK_WINDOW`+1 cycles after `val_valid_o`.
- `timeout_o` asserts `BUSY_TIMEOUT` cycles after entering RUN.
- All outputs are registered, with no combinational input-to-output paths. Exception: `in_ready_o`, which is a register-derived compare.

## Structure
- `trans_pkg` holds:
  - `TRANS_W=128`, `BIT_BLOCK_START=9`.
  - Field offset constants (sender 127:80, receiver 79:32, amount 31:10).
  - `disp_state_t` enum (IDLE, ACK, RUN).
- The validator migrates to `trans_pkg` constants later.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH): register array, wrap-around pointers with an extra bit, full/empty flags, zero-latency head read.

## Test plan
- Single word, validator model busy 5 cycles: accept at N → `val_valid_o` at N+2 with identical data; `dispatched_cnt_o=1`; next issue is not possible before busy falls.
- Burst of 20 words with `FIFO_DEPTH=16` and a slow validator (busy 40): `in_ready_o` drops after 16 are buffered. All 20 are issued in order with no loss or duplication, and `block_cnt_o` matches the count of bit-9 words.
- Validator model never raises busy: `issue_err_o` pulses 3 cycles after `val_valid_o`. FSM returns to IDLE, the next word issues, and `dispatched_cnt_o` counts both.
- Busy stuck high, `BUSY_TIMEOUT=100`: `timeout_o` pulses once at 100 cycles in RUN. No further issue occurs until busy drops, then the queue resumes.
- Push into an empty FIFO while busy is low: the word is not issued the same cycle and issues exactly 2 cycles after accept. Simultaneous push and pop at count 8 leaves count at 8.
- `rst_n` asserted asynchronously mid-RUN with 5 words queued: outputs go to reset values immediately, the FIFO is empty after release, and the first post-reset word issues normally with `dispatched_cnt_o=1`.

Source files
------------

// File: rtl/trans_dispatcher_pkg.sv
// Shared transaction word layout and dispatcher state encoding.
// The validator is expected to move onto these constants as well.
package trans_pkg;

  localparam int unsigned TRANS_W         = 128;
  localparam int unsigned BIT_BLOCK_START = 9;

  localparam int unsigned SENDER_MSB   = 127;
  localparam int unsigned SENDER_LSB   = 80;
  localparam int unsigned RECEIVER_MSB = 79;
  localparam int unsigned RECEIVER_LSB = 32;
  localparam int unsigned AMOUNT_MSB   = 31;
  localparam int unsigned AMOUNT_LSB   = 10;
  localparam int unsigned FLAGS_MSB    = 9;
  localparam int unsigned FLAGS_LSB    = 0;

  localparam int unsigned SENDER_W   = SENDER_MSB - SENDER_LSB + 1;
  localparam int unsigned RECEIVER_W = RECEIVER_MSB - RECEIVER_LSB + 1;
  localparam int unsigned AMOUNT_W   = AMOUNT_MSB - AMOUNT_LSB + 1;
  localparam int unsigned FLAGS_W    = FLAGS_MSB - FLAGS_LSB + 1;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    RUN
  } disp_state_t;

  function automatic logic is_block_start(input logic [TRANS_W-1:0] word);
    return word[BIT_BLOCK_START];
  endfunction

  function automatic logic [TRANS_W-1:0] pack_trans(
    input logic [SENDER_W-1:0]   sender,
    input logic [RECEIVER_W-1:0] receiver,
    input logic [AMOUNT_W-1:0]   amount,
    input logic [FLAGS_W-1:0]    flags
  );
    logic [TRANS_W-1:0] word;
    word = '0;
    word[SENDER_MSB:SENDER_LSB]     = sender;
    word[RECEIVER_MSB:RECEIVER_LSB] = receiver;
    word[AMOUNT_MSB:AMOUNT_LSB]     = amount;
    word[FLAGS_MSB:FLAGS_LSB]       = flags;
    return word;
  endfunction

endpackage

// File: rtl/trans_dispatcher_if.sv
// Upstream stream and validator-side signals of the transaction dispatcher.
// master = environment (upstream + validator), slave = dispatcher.
interface trans_dispatcher_if;
  import trans_pkg::*;

  logic [TRANS_W-1:0] in_data_i;
  logic               in_valid_i;
  logic               in_ready_o;
  logic [TRANS_W-1:0] val_data_o;
  logic               val_valid_o;
  logic               val_busy_i;

  modport master (
    output in_data_i, in_valid_i, val_busy_i,
    input  in_ready_o, val_data_o, val_valid_o
  );

  modport slave (
    input  in_data_i, in_valid_i, val_busy_i,
    output in_ready_o, val_data_o, val_valid_o
  );

endinterface

// File: rtl/trans_dispatcher_sync_fifo.sv
// Synchronous FIFO with extra-bit wrap pointers and a zero-latency head read.
module sync_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0] PTR_ONE  = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [AW:0]      w_count;
  logic             w_wr;
  logic             w_rd;

  assign w_count = r_wptr - r_rptr;
  assign o_full  = (w_count == FULL_CNT);
  assign o_empty = (w_count == '0);
  assign w_wr    = i_push && !o_full;
  assign w_rd    = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + PTR_ONE;
      if (w_rd) r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Storage needs no reset: emptiness is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/trans_dispatcher.sv
// Buffers upstream transactions and issues them one at a time to an idle
// validator, flagging missing acknowledgement and busy hangs.
module trans_dispatcher
  import trans_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned ACK_WINDOW   = 2,
  parameter int unsigned BUSY_TIMEOUT = 32768
) (
  input  logic              clk,
  input  logic              rst_n,
  trans_dispatcher_if.slave bus,
  output logic              issue_err_o,
  output logic              timeout_o,
  output logic [31:0]       dispatched_cnt_o,
  output logic [15:0]       block_cnt_o
);

  localparam logic [31:0] ACK_LIMIT = 32'(ACK_WINDOW);
  localparam logic [31:0] RUN_LIMIT = 32'(BUSY_TIMEOUT - 1);

  disp_state_t        r_state;
  logic [31:0]        r_timer;
  logic [TRANS_W-1:0] r_val_data;
  logic               r_val_valid;
  logic               r_issue_err;
  logic               r_timeout;
  logic [31:0]        r_dispatched;
  logic [15:0]        r_block;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [TRANS_W-1:0] w_head;

  assign w_push = bus.in_valid_i && !w_full;
  assign w_pop  = (r_state == IDLE) && !w_empty && !bus.val_busy_i;

  sync_fifo #(
    .WIDTH (TRANS_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (bus.in_data_i),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_timer      <= '0;
      r_val_data   <= '0;
      r_val_valid  <= 1'b0;
      r_issue_err  <= 1'b0;
      r_timeout    <= 1'b0;
      r_dispatched <= '0;
      r_block      <= '0;
    end else begin
      r_val_valid <= 1'b0;
      r_issue_err <= 1'b0;
      r_timeout   <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_val_data   <= w_head;
            r_val_valid  <= 1'b1;
            r_dispatched <= r_dispatched + 32'd1;
            if (is_block_start(w_head)) r_block <= r_block + 16'd1;
            r_timer      <= '0;
            r_state      <= ACK;
          end
        end
        // Window count is tested before incrementing, so the error pulse
        // lands ACK_WINDOW+1 cycles after the issue pulse.
        ACK: begin
          if (bus.val_busy_i) begin
            r_timer <= '0;
            r_state <= RUN;
          end else if (r_timer == ACK_LIMIT) begin
            r_issue_err <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_timer <= r_timer + 32'd1;
          end
        end
        RUN: begin
          if (!bus.val_busy_i) begin
            r_state <= IDLE;
          end else if (r_timer == RUN_LIMIT) begin
            r_timeout <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_timer <= r_timer + 32'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready_o  = !w_full;
  assign bus.val_data_o  = r_val_data;
  assign bus.val_valid_o = r_val_valid;
  assign issue_err_o      = r_issue_err;
  assign timeout_o        = r_timeout;
  assign dispatched_cnt_o = r_dispatched;
  assign block_cnt_o      = r_block;

endmodule

// File: tb/tb_trans_dispatcher.sv
// Randomized bench for trans_dispatcher: upstream driver, validator model
// and a queue-based scoreboard of expected issue order, timing and counters.
module tb_trans_dispatcher;
  import trans_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned ACKW  = 2;
  localparam int unsigned TMO   = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_err;
  logic        tmo;
  logic [31:0] disp_cnt;
  logic [15:0] blk_cnt;

  trans_dispatcher_if bus();

  trans_dispatcher #(
    .FIFO_DEPTH   (DEPTH),
    .ACK_WINDOW   (ACKW),
    .BUSY_TIMEOUT (TMO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus.slave),
    .issue_err_o      (issue_err),
    .timeout_o        (tmo),
    .dispatched_cnt_o (disp_cnt),
    .block_cnt_o      (blk_cnt)
  );

  always #5 clk = ~clk;

  typedef enum int {V_NORMAL, V_NEVER, V_STUCK} vmode_t;

  int unsigned  n_tests = 0;
  int unsigned  n_fail  = 0;
  vmode_t       vmode;
  int unsigned  vdur, busy_left;
  logic         busy, rand_dur, gaps;
  logic [127:0] send_q[$];
  logic [127:0] exp_q[$];
  int           cyc, accepted, issued, blocks, last_acc, last_val, err_due, to_due;
  logic         p_valid, p_ready, p_busy, prev_v, v_now, full_seen;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand_word();
    logic [63:0] a, b;
    a = {$urandom(), $urandom()};
    b = {$urandom(), $urandom()};
    return pack_trans(a[47:0], b[47:0], 22'($urandom()), 10'($urandom()));
  endfunction

  // One clock cycle: observe at the negedge, update the models, drive inputs.
  task automatic tick();
    logic [127:0] e;
    logic         hold, drive;
    @(negedge clk);
    cyc++;
    if (p_valid && p_ready) begin
      exp_q.push_back(send_q.pop_front());
      accepted++;
      last_acc = cyc - 1;
    end
    v_now = bus.val_valid_o;
    if (p_busy) check("busy_gate", 128'(v_now), 128'(0));
    if (v_now) begin
      check("no_b2b", 128'(prev_v), 128'(0));
      if (exp_q.size() == 0) begin
        check("spurious_issue", 128'(v_now), 128'(0));
      end else begin
        e = exp_q.pop_front();
        issued++;
        if (e[BIT_BLOCK_START]) blocks++;
        check("val_data", bus.val_data_o, e);
        check("dispatched_cnt", 128'(disp_cnt), 128'(issued));
        check("block_cnt", 128'(blk_cnt), 128'(blocks));
      end
      last_val = cyc;
      if (vmode == V_NEVER) err_due = cyc + int'(ACKW) + 1;
      if (vmode == V_STUCK) to_due = cyc + 1 + int'(TMO);  // RUN begins the cycle after the issue
    end
    check("issue_err", 128'(issue_err), 128'(cyc == err_due));
    check("timeout", 128'(tmo), 128'(cyc == to_due));
    check("in_ready", 128'(bus.in_ready_o), 128'((accepted - issued) < int'(DEPTH)));
    if (!bus.in_ready_o) full_seen = 1'b1;
    prev_v = v_now;

    case (vmode)
      V_NORMAL: begin
        if (v_now) begin
          if (rand_dur) vdur = $urandom_range(1, 8);
          busy      = 1'b1;
          busy_left = vdur - 1;
        end else if (busy) begin
          if (busy_left == 0) busy = 1'b0;
          else busy_left--;
        end
      end
      V_NEVER: busy = 1'b0;
      default: if (v_now) busy = 1'b1;
    endcase
    bus.val_busy_i = busy;
    p_busy = busy;

    hold  = p_valid && !p_ready;
    drive = (send_q.size() > 0) && (hold || !gaps || ($urandom_range(0, 3) != 0));
    bus.in_valid_i = drive;
    bus.in_data_i  = drive ? send_q[0] : {$urandom(), $urandom(), $urandom(), $urandom()};
    p_valid = drive;
    p_ready = bus.in_ready_o;
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (v_now) break;
    end
    check("wait_valid", 128'(v_now), 128'(1));
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (send_q.size() == 0 && exp_q.size() == 0 && !busy) break;
      tick();
    end
    check("drain", 128'(send_q.size() + exp_q.size()), 128'(0));
  endtask

  task automatic set_busy(input logic b);
    busy = b;
    bus.val_busy_i = b;
    p_busy = b;
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    bus.in_valid_i = 1'b0;
    #1;
    check("rst_val_valid", 128'(bus.val_valid_o), 128'(0));
    check("rst_val_data", bus.val_data_o, 128'(0));
    check("rst_issue_err", 128'(issue_err), 128'(0));
    check("rst_timeout", 128'(tmo), 128'(0));
    check("rst_disp_cnt", 128'(disp_cnt), 128'(0));
    check("rst_blk_cnt", 128'(blk_cnt), 128'(0));
    send_q.delete();
    exp_q.delete();
    accepted = 0; issued = 0; blocks = 0;
    err_due = -1; to_due = -1;
    p_valid = 1'b0; p_ready = 1'b0; prev_v = 1'b0;
    vmode = V_NORMAL; busy_left = 0;
    set_busy(1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int first_val, base;
    logic [127:0] w;
    rst_n = 1'b1;
    cyc = 0; vdur = 5; rand_dur = 1'b0; gaps = 1'b0; full_seen = 1'b0;
    bus.in_data_i = '0;
    @(negedge clk);
    do_reset();

    // Single word into an empty FIFO with an idle validator; next issue waits on busy.
    vdur = 5;
    send_q.push_back(rand_word());
    wait_valid(20);
    check("latency", 128'(last_val - last_acc), 128'(2));
    check("single_cnt", 128'(disp_cnt), 128'(1));
    first_val = last_val;
    send_q.push_back(rand_word());
    wait_valid(40);
    check("throughput", 128'(last_val - first_val), 128'(vdur + 2));
    wait_drain(40);

    // Burst of 20 against a slow validator: FIFO must fill and backpressure.
    base = issued;
    vdur = 40;
    full_seen = 1'b0;
    for (int i = 0; i < 20; i++) send_q.push_back(rand_word());
    wait_drain(2000);
    check("burst_full_seen", 128'(full_seen), 128'(1));
    check("burst_issued", 128'(issued - base), 128'(20));

    // Validator never acknowledges: error pulse, word dropped, next one issues.
    base = issued;
    vmode = V_NEVER;
    send_q.push_back(rand_word());
    send_q.push_back(rand_word());
    wait_drain(100);
    repeat (6) tick();
    check("never_cnt", 128'(disp_cnt), 128'(base + 2));

    // Busy stuck high: one timeout, no issue until busy drops, then resume.
    base = issued;
    vmode = V_STUCK;
    for (int i = 0; i < 3; i++) send_q.push_back(rand_word());
    wait_valid(20);
    repeat (TMO + 20) tick();
    check("stuck_held", 128'(issued - base), 128'(1));
    vmode = V_NORMAL;
    vdur = 3;
    set_busy(1'b0);
    wait_drain(200);
    check("stuck_resume", 128'(issued - base), 128'(3));

    // Random traffic with upstream gaps and varying busy lengths.
    base = issued;
    gaps = 1'b1;
    rand_dur = 1'b1;
    for (int i = 0; i < 40; i++) send_q.push_back(rand_word());
    wait_drain(2000);
    check("mix_issued", 128'(issued - base), 128'(40));
    gaps = 1'b0;
    rand_dur = 1'b0;

    // Reset mid-RUN with five words queued.
    vdur = 60;
    for (int i = 0; i < 6; i++) send_q.push_back(rand_word());
    wait_valid(20);
    repeat (10) tick();
    check("queued_before_rst", 128'(accepted - issued), 128'(5));
    do_reset();
    repeat (5) tick();
    vdur = 4;
    w = rand_word();
    send_q.push_back(w);
    wait_valid(20);
    check("post_rst_latency", 128'(last_val - last_acc), 128'(2));
    check("post_rst_cnt", 128'(disp_cnt), 128'(1));
    check("post_rst_data", bus.val_data_o, w);
    wait_drain(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
